// File: rtl/lcd_write_sequencer_if.sv
// CPU custom-instruction slot and LCD pin bundle for the LCD write sequencer.
// The slave modport is the sequencer; the master modport is the CPU/board side.
interface lcd_write_sequencer_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        done;
  logic [31:0] result;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [7:0]  lcd_data;

  modport slave (
    input  clk_en, start, dataA, dataB,
    output done, result, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport master (
    output clk_en, start, dataA, dataB,
    input  done, result, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Sequences one HD44780 write (setup, EN pulse, hold, exec wait), then a 1-cycle done.
// Latency T_SETUP+T_EN+T_HOLD+wait+1 enabled cycles; clk_en=0 stalls all state; busy starts are dropped.
module lcd_write_sequencer #(
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 12,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_SHORT = 2000,
  parameter int T_WAIT_LONG  = 80000
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_write_sequencer_if.slave  bus
);

  localparam logic [19:0] CNT_SETUP = 20'(T_SETUP);
  localparam logic [19:0] CNT_EN    = 20'(T_EN);
  localparam logic [19:0] CNT_HOLD  = 20'(T_HOLD);
  localparam logic [19:0] CNT_SHORT = 20'(T_WAIT_SHORT);
  localparam logic [19:0] CNT_LONG  = 20'(T_WAIT_LONG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] result_q, result_d;
  logic        lcd_en_q, lcd_en_d;
  logic        done_q, done_d;
  logic        long_wait;
  logic        cnt_last;

  // Clear display / return home need the long execution time.
  assign long_wait = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
  assign cnt_last  = (cnt_q == 20'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    byte_d   = byte_q;
    result_d = result_q;
    if (bus.clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rs_d    = bus.dataA[0];
            byte_d  = bus.dataB[7:0];
            cnt_d   = CNT_SETUP;
            state_d = S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_last) begin
            cnt_d   = CNT_EN;
            state_d = S_PULSE;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        S_PULSE: begin
          if (cnt_last) begin
            cnt_d   = CNT_HOLD;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        S_HOLD: begin
          if (cnt_last) begin
            cnt_d   = long_wait ? CNT_LONG : CNT_SHORT;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        S_WAIT: begin
          if (cnt_last) begin
            cnt_d    = 20'd0;
            result_d = {23'd0, rs_q, byte_q};
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - 20'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          cnt_d   = 20'd0;
          state_d = S_IDLE;
        end
      endcase
    end
    // Registered strobes keep the LCD pins glitch-free and hold through stalls.
    lcd_en_d = (state_d == S_PULSE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 20'd0;
      rs_q     <= 1'b0;
      byte_q   <= 8'd0;
      result_q <= 32'd0;
      lcd_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      byte_q   <= byte_d;
      result_q <= result_d;
      lcd_en_q <= lcd_en_d;
      done_q   <= done_d;
    end
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = lcd_en_q;
  assign bus.lcd_data = byte_q;

  logic unused_bits;
  assign unused_bits = ^{bus.dataA[31:1], bus.dataB[31:8]};

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer: cycle index 1 is the cycle right after the start-sampling edge.
module tb_lcd_write_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_write_sequencer_if bus ();

  lcd_write_sequencer #(
    .T_SETUP(2), .T_EN(3), .T_HOLD(2), .T_WAIT_SHORT(5), .T_WAIT_LONG(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one write and observes it until done; returns in the cycle after done.
  task automatic do_write(input logic rs, input logic [7:0] b, input int busy_cyc,
                          input int stall_cyc, input int stall_len,
                          output int lat, output int en_first, output int en_cnt, output int en_raw);
    int cyc;
    bit fin;
    lat = 0; en_first = 0; en_cnt = 0; en_raw = 0; fin = 1'b0;
    bus.dataA  = {31'h7FFF_FFFF, rs};
    bus.dataB  = {24'hABCDEF, b};
    bus.start  = 1'b1;
    bus.clk_en = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.dataA = 32'h0;
    bus.dataB = 32'h0000_0055;
    cyc = 1;
    while (!fin && cyc < 200) begin
      bus.start  = (cyc == busy_cyc);
      bus.clk_en = !(cyc >= stall_cyc && cyc < stall_cyc + stall_len);
      if (bus.lcd_en) begin
        en_raw++;
        if (en_first == 0) en_first = cyc;
        if (bus.clk_en) en_cnt++;
      end
      if (bus.done && bus.clk_en) begin
        lat = cyc;
        fin = 1'b1;
      end
      tick();
      cyc++;
    end
    bus.start  = 1'b0;
    bus.clk_en = 1'b1;
  endtask

  task automatic idle_watch(input int n, output int dones, output int ens);
    dones = 0; ens = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.done) dones++;
      if (bus.lcd_en) ens++;
      tick();
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] b;
    int         lat;
    string      tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, en_first, en_cnt, en_raw, dones, ens;

    vecs[0] = '{1'b0, 8'h01, 28, "clear"};
    vecs[1] = '{1'b0, 8'h38, 13, "funcset"};
    vecs[2] = '{1'b0, 8'h03, 28, "home_hi"};
    vecs[3] = '{1'b0, 8'h04, 13, "entry"};
    vecs[4] = '{1'b1, 8'h01, 13, "char01"};
    vecs[5] = '{1'b0, 8'h02, 28, "home"};

    reset      = 1'b1;
    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.dataA  = 32'h0;
    bus.dataB  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_en", {31'd0, bus.lcd_en}, 32'd0);
    check("rst_rs", {31'd0, bus.lcd_rs}, 32'd0);
    check("rst_rw", {31'd0, bus.lcd_rw}, 32'd0);
    check("rst_data", {24'd0, bus.lcd_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Character write
    do_write(1'b1, 8'h41, 0, 0, 0, lat, en_first, en_cnt, en_raw);
    check("char_lat", lat, 13);
    check("char_en_first", en_first, 3);
    check("char_en_cnt", en_cnt, 3);
    check("char_en_raw", en_raw, 3);
    check("char_result", bus.result, 32'h141);
    check("char_rs", {31'd0, bus.lcd_rs}, 32'd1);
    check("char_data", {24'd0, bus.lcd_data}, 32'h41);
    check("char_rw", {31'd0, bus.lcd_rw}, 32'd0);

    // Command wait selection
    foreach (vecs[i]) begin
      do_write(vecs[i].rs, vecs[i].b, 0, 0, 0, lat, en_first, en_cnt, en_raw);
      check({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].tag, "_result"}, bus.result, {23'd0, vecs[i].rs, vecs[i].b});
    end

    // Start while busy is dropped
    do_write(1'b1, 8'h41, 4, 0, 0, lat, en_first, en_cnt, en_raw);
    check("busy_lat", lat, 13);
    check("busy_data", {24'd0, bus.lcd_data}, 32'h41);
    check("busy_result", bus.result, 32'h141);
    idle_watch(30, dones, ens);
    check("busy_extra_done", dones, 0);
    check("busy_extra_en", ens, 0);

    // Four stalled cycles in the middle of the EN pulse
    do_write(1'b1, 8'h41, 0, 4, 4, lat, en_first, en_cnt, en_raw);
    check("stall_lat", lat, 17);
    check("stall_en_cnt", en_cnt, 3);
    check("stall_en_raw", en_raw, 7);

    // Start coincident with done is dropped
    do_write(1'b0, 8'h38, 13, 0, 0, lat, en_first, en_cnt, en_raw);
    check("donestart_lat", lat, 13);
    idle_watch(30, dones, ens);
    check("donestart_extra_done", dones, 0);
    check("donestart_extra_en", ens, 0);

    // Asynchronous reset in the middle of the EN pulse
    bus.dataA = 32'h0;
    bus.dataB = 32'h77;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("rstmid_en_before", {31'd0, bus.lcd_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_en", {31'd0, bus.lcd_en}, 32'd0);
    check("rstmid_result", bus.result, 32'd0);
    check("rstmid_data", {24'd0, bus.lcd_data}, 32'd0);
    #1 reset = 1'b0;
    tick();
    idle_watch(30, dones, ens);
    check("rstmid_no_done", dones, 0);
    check("rstmid_no_en", ens, 0);
    do_write(1'b0, 8'h38, 0, 0, 0, lat, en_first, en_cnt, en_raw);
    check("rstmid_next_lat", lat, 13);
    check("rstmid_next_result", bus.result, 32'h038);

    // Back-to-back writes
    do_write(1'b1, 8'h42, 0, 0, 0, lat, en_first, en_cnt, en_raw);
    check("b2b_first_lat", lat, 13);
    check("b2b_first_result", bus.result, 32'h142);
    do_write(1'b1, 8'h43, 0, 0, 0, lat, en_first, en_cnt, en_raw);
    check("b2b_second_lat", lat, 13);
    check("b2b_second_result", bus.result, 32'h143);
    check("b2b_second_data", {24'd0, bus.lcd_data}, 32'h43);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
